filtr_sched: RTL and testbench

//  Sample scheduler in front of the adaptive IIR core (filtr_a). Accepts input samples on a

---
 rtl/filtr_pkg.sv | 15 +
 rtl/sample_fifo.sv | 52 +++++
 rtl/filtr_sched.sv | 136 +++++++++++++
 tb/tb_filtr_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filtr_pkg.sv
// Shared definitions for the filtr_sched sample scheduler.
//   state_t      : scheduler FSM encoding (IDLE=0, LOAD=1, TRIG=2, BUSY=3)
//   CORE_LAT_DEF : default core latency in cycles, from trigger back to core IDLE
package filtr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        TRIG = 2'd2,
        BUSY = 2'd3
    } state_t;

    localparam int CORE_LAT_DEF = 6;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO that buffers input samples ahead of the core scheduler.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (clears pointers only)
//   push, din    : write din when push=1 and the FIFO is not full
//   pop          : discard the head entry when pop=1 and the FIFO is not empty
//   full, empty  : occupancy flags
//   dout         : current head entry (valid while empty=0)
module sample_fifo #(
    parameter int DATA_SIZE  = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_SIZE-1:0] din,
    output logic                 full,
    output logic                 empty,
    output logic [DATA_SIZE-1:0] dout
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/filtr_sched.sv
// Sample scheduler in front of the adaptive IIR core (filtr_a).
// Buffers incoming samples, launches one core computation per sample, waits
// out the fixed core latency, and presents each result on an output stream.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   en                      : 1 = launch computations, 0 = finish current one then hold
//   in_data/in_valid/in_ready : input sample stream (in_ready = FIFO not full)
//   core_data_in, core_trig : core sample input (held per computation) and start pulse
//   core_data_out           : core filtered result
//   out_data/out_valid/out_ready : output sample stream, one-deep
//   busy                    : FSM not in IDLE
//   overflow, drop_cnt      : sticky drop flag and saturating drop count
module filtr_sched
    import filtr_pkg::*;
#(
    parameter int DATA_SIZE  = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int CORE_LAT   = CORE_LAT_DEF,
    parameter int DROP_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_SIZE-1:0] core_data_in,
    output logic                 core_trig,
    input  logic [DATA_SIZE-1:0] core_data_out,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 overflow,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam int CNT_W = $clog2(CORE_LAT);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 fifo_push;
    logic [DATA_SIZE-1:0] fifo_dout;
    logic                 drop_evt;
    logic                 capture;

    // A pop in the same cycle never frees space for a sample arriving while full.
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;
    assign drop_evt  = in_valid && fifo_full;
    assign busy      = (state_q != IDLE);
    assign capture   = (state_q == BUSY) && (cnt_q == '0);

    sample_fifo #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (in_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dout    (fifo_dout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // A launch needs the output slot free, or freed by a handshake this cycle.
    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        core_trig = 1'b0;
        case (state_q)
            IDLE: if (en && !fifo_empty && (!out_valid || out_ready)) state_d = LOAD;
            LOAD: begin
                fifo_pop = 1'b1;
                state_d  = TRIG;
            end
            TRIG: begin
                core_trig = 1'b1;
                state_d   = BUSY;
            end
            BUSY: if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // core_data_in changes only in LOAD, so it is stable across both core sample points.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_data_in <= '0;
            cnt_q        <= '0;
        end else begin
            if (state_q == LOAD) core_data_in <= fifo_dout;
            if (state_q == TRIG)      cnt_q <= CNT_W'(CORE_LAT - 2);
            else if (state_q == BUSY) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Capture lands as the core returns to IDLE; its result is already valid then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (capture) begin
            out_data  <= core_data_out;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop_evt) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

endmodule

// File: tb/tb_filtr_sched.sv
`timescale 1ns/1ps
module tb_filtr_sched;

    localparam int DW       = 24;
    localparam int CORE_LAT = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] core_data_in;
    logic          core_trig;
    logic [DW-1:0] core_data_out;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          overflow;
    logic [15:0]   drop_cnt;

    always #50 clk = ~clk;

    filtr_sched dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .core_data_in  (core_data_in),
        .core_trig     (core_trig),
        .core_data_out (core_data_out),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behaviour of the filter core: result depends only on the sample it takes.
    function automatic logic [DW-1:0] core_f(input logic [DW-1:0] x);
        logic signed [DW-1:0] s;
        s = x;
        return DW'(s >>> 1) + 24'h012345;
    endfunction

    // Core stand-in: IDLE(ph=0), S1..S5; samples data_in in S1 and S4, result from S2 on,
    // garbage in S1 so an early capture shows up.
    logic [2:0]    ph;
    logic [DW-1:0] x1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph            <= '0;
            x1            <= '0;
            core_data_out <= '0;
        end else if (ph == 3'd0) begin
            if (core_trig) begin
                ph            <= 3'd1;
                core_data_out <= DW'($urandom);
            end
        end else begin
            ph <= (ph == 3'd5) ? 3'd0 : ph + 3'd1;
            if (ph == 3'd1) begin
                x1            <= core_data_in;
                core_data_out <= core_f(core_data_in);
            end
        end
    end

    // Scoreboard: every accepted input must come out, in order, as core_f(input).
    logic [DW-1:0] exp_q[$];
    int            exp_drop = 0;
    int            n_out = 0;
    int            n_trig = 0;
    int            cyc = 0;
    int            last_trig = 0;
    bit            have_last = 0;
    logic          prev_ov = 0;
    logic          prev_ordy = 0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            have_last = 0;
            prev_ov   = 0;
        end else begin
            if (core_trig) begin
                chk("trig_core_idle", 32'(ph), 0);
                chk("trig_no_ov", 32'(out_valid), 0);
                if (have_last) chk("trig_gap", 32'((cyc - last_trig) >= CORE_LAT + 1), 1);
                have_last = 1;
                last_trig = cyc;
                n_trig++;
            end
            if (ph == 3'd4) chk("din_hold", 32'(core_data_in), 32'(x1));
            if (prev_ov && !prev_ordy) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) chk("out_extra", 1, 0);
                else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (in_valid) begin
                if (in_ready) exp_q.push_back(core_f(in_data));
                else exp_drop++;
            end
            prev_ov   = out_valid;
            prev_ordy = out_ready;
            prev_data = out_data;
        end
    end

    task automatic send(input logic [DW-1:0] x);
        in_data  = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 32'(k < 1000), 1);
    endtask

    task automatic wait_trig();
        int k = 0;
        int t0 = n_trig;
        while (n_trig == t0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("trig_timeout", 32'(n_trig != t0), 1);
    endtask

    // Send one sample into an idle scheduler and measure cycles until out_valid.
    task automatic latency_probe(input string tag, input logic [DW-1:0] x);
        int n = 0;
        send(x);
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, n, CORE_LAT + 2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0, t0;
        reset_n   = 1'b0;
        en        = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_trig", 32'(core_trig), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_core_din", 32'(core_data_in), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // single sample
        en = 1'b1;
        out_ready = 1'b1;
        latency_probe("lat_single", 24'h000100);
        drain();
        chk("single_drop", 32'(drop_cnt), 0);
        chk("single_ovf", 32'(overflow), 0);

        // burst of four
        o0 = n_out;
        for (int i = 0; i < 4; i++) begin
            chk("burst_ready", 32'(in_ready), 1);
            send(DW'($urandom));
        end
        drain();
        chk("burst_count", n_out - o0, 4);

        // overflow and backpressure
        out_ready = 1'b0;
        o0 = n_out;
        t0 = n_trig;
        for (int i = 0; i < 7; i++) send(DW'($urandom));
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drop", 32'(drop_cnt), 2);
        chk("ovf_model_drop", 32'(drop_cnt), 32'(exp_drop));
        chk("ovf_in_ready", 32'(in_ready), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_one_launch", n_trig - t0, 1);
        out_ready = 1'b1;
        drain();
        chk("ovf_out_count", n_out - o0, 5);
        chk("ovf_drop_after", 32'(drop_cnt), 2);
        chk("ovf_ready_after", 32'(in_ready), 1);

        // en dropped mid-computation
        o0 = n_out;
        send(DW'($urandom));
        send(DW'($urandom));
        wait_trig();
        en = 1'b0;
        t0 = n_trig;
        repeat (30) @(negedge clk);
        chk("en0_out", n_out - o0, 1);
        chk("en0_no_trig", n_trig - t0, 0);
        chk("en0_busy", 32'(busy), 0);
        chk("en0_pending", exp_q.size(), 1);
        en = 1'b1;
        drain();
        chk("en1_out", n_out - o0, 2);

        // reset mid-computation
        send(DW'($urandom));
        wait_trig();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_drop", 32'(drop_cnt), 0);
        chk("mrst_ovf", 32'(overflow), 0);
        chk("mrst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        o0 = n_out;
        latency_probe("lat_after_rst", DW'($urandom));
        drain();
        chk("after_rst_out", n_out - o0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 2) == 0);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 7) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        en        = 1'b1;
        drain();
        chk("rand_drop", 32'(drop_cnt), 32'(exp_drop));
        chk("rand_ovf", 32'(overflow), 32'(exp_drop != 0));
        chk("rand_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
